// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one UART transmitter among NREQ byte producers. One byte is moved per
// grant: the winner's byte is latched onto uart_din, ack/uart_wr_en pulse for one
// cycle, then the arbiter waits for the transmitter to start and finish the frame.
// A transmitter that never raises tx_busy within START_TMO cycles is abandoned
// with a one-cycle drop pulse; the byte is not retried.
//
// Optional feature: define UART_ARB_PRIO0_EN to give requester 0 strict priority
// over the round-robin among requesters 1..NREQ-1.
module uart_tx_arb #(
   parameter int NREQ      = 4,
   parameter int START_TMO = 4
) (
   input  logic              clk_50m,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        uart_din,
   output logic              uart_wr_en,
   input  logic              uart_tx_busy,
   output logic [2:0]        grant_id,
   output logic              busy,
   output logic              drop
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] TMO_CNT  = 4'(START_TMO);
   localparam logic [2:0] PTR_INIT = 3'(NREQ - 1);
   localparam logic [3:0] NREQ_CNT = 4'(NREQ);

   // State and registered outputs
   state_t          state_r;
   state_t          state_nxt_s;
   logic [2:0]      ptr_r;
   logic [2:0]      ptr_nxt_s;
   logic [3:0]      cnt_r;
   logic [3:0]      cnt_nxt_s;
   logic [NREQ-1:0] ack_r;
   logic [NREQ-1:0] ack_nxt_s;
   logic            wr_en_r;
   logic            wr_en_nxt_s;
   logic [7:0]      din_r;
   logic [7:0]      din_nxt_s;
   logic [2:0]      gid_r;
   logic [2:0]      gid_nxt_s;
   logic            busy_r;
   logic            drop_r;
   logic            drop_nxt_s;

   // Arbitration signals
   logic [7:0]      req_ext_s;
   logic [63:0]     data_ext_s;
   logic [3:0]      cand_s;
   logic            rr_vld_s;
   logic [2:0]      rr_id_s;
   logic            win_vld_s;
   logic [2:0]      win_id_s;
   logic [2:0]      ptr_upd_s;
   logic [7:0]      win_onehot_s;
   logic [7:0]      win_byte_s;

   // Widen request and data vectors to the 8-requester maximum so a 3-bit index always fits.
   always_comb begin
      req_ext_s                = 8'h00;
      data_ext_s               = 64'h0;
      req_ext_s[NREQ-1:0]      = req;
      data_ext_s[8*NREQ-1:0]   = req_data;
   end

   // Round-robin search: first requester at or after ptr+1, wrapping modulo NREQ.
   always_comb begin
      rr_vld_s = 1'b0;
      rr_id_s  = 3'd0;
      cand_s   = 4'd0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = {1'b0, ptr_r} + 4'(k);
         if (cand_s >= NREQ_CNT) begin
            cand_s = cand_s - NREQ_CNT;
         end else begin
            cand_s = cand_s;
         end
         if (!rr_vld_s && req_ext_s[cand_s[2:0]]) begin
            rr_vld_s = 1'b1;
            rr_id_s  = cand_s[2:0];
         end else begin
            rr_vld_s = rr_vld_s;
         end
      end
   end

`ifdef UART_ARB_PRIO0_EN
   // Requester 0 overrides the round-robin and never moves the pointer.
   always_comb begin
      if (req_ext_s[0]) begin
         win_vld_s = 1'b1;
         win_id_s  = 3'd0;
         ptr_upd_s = ptr_r;
      end else begin
         win_vld_s = rr_vld_s;
         win_id_s  = rr_id_s;
         ptr_upd_s = rr_id_s;
      end
   end
`else
   // Pure round-robin: the pointer follows every winner.
   always_comb begin
      win_vld_s = rr_vld_s;
      win_id_s  = rr_id_s;
      ptr_upd_s = rr_id_s;
   end
`endif

   // Decode the winner into an ack pattern and pick out its byte.
   always_comb begin
      win_onehot_s = 8'h01 << win_id_s;
      win_byte_s   = data_ext_s[{win_id_s, 3'b000} +: 8];
   end

   // Next-state and next-output logic; pulses default low, held values default to current.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      cnt_nxt_s   = cnt_r;
      ack_nxt_s   = {NREQ{1'b0}};
      wr_en_nxt_s = 1'b0;
      din_nxt_s   = din_r;
      gid_nxt_s   = gid_r;
      drop_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A busy transmitter (e.g. still sending after a reset) blocks any grant.
            if (win_vld_s && !uart_tx_busy) begin
               state_nxt_s = ST_ISSUE;
               ack_nxt_s   = win_onehot_s[NREQ-1:0];
               wr_en_nxt_s = 1'b1;
               din_nxt_s   = win_byte_s;
               gid_nxt_s   = win_id_s;
               ptr_nxt_s   = ptr_upd_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (uart_tx_busy) begin
               state_nxt_s = ST_WAIT_DONE;
            end else if (cnt_r + 4'd1 == TMO_CNT) begin
               // Transmitter never started: give up on this byte.
               drop_nxt_s  = 1'b1;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s   = cnt_r + 4'd1;
               state_nxt_s = ST_WAIT_START;
            end
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; synchronous reset returns everything to idle.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_r <= ST_IDLE;
         ptr_r   <= PTR_INIT;
         cnt_r   <= 4'd0;
         ack_r   <= {NREQ{1'b0}};
         wr_en_r <= 1'b0;
         din_r   <= 8'h00;
         gid_r   <= 3'd0;
         busy_r  <= 1'b0;
         drop_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ack_r   <= ack_nxt_s;
         wr_en_r <= wr_en_nxt_s;
         din_r   <= din_nxt_s;
         gid_r   <= gid_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         drop_r  <= drop_nxt_s;
      end
   end

   assign ack        = ack_r;
   assign uart_wr_en = wr_en_r;
   assign uart_din   = din_r;
   assign grant_id   = gid_r;
   assign busy       = busy_r;
   assign drop       = drop_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios plus randomized traffic, with a
// transaction-level reference model checked against the DUT on every cycle.
`timescale 1ns/1ps
module tb_uart_tx_arb;
   localparam int N   = 4;
   localparam int TMO = 4;

   logic           clk_50m = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   ack;
   logic [7:0]     uart_din;
   logic           uart_wr_en;
   logic           uart_tx_busy;
   logic [2:0]     grant_id;
   logic           busy;
   logic           drop;

   uart_tx_arb #(.NREQ(N), .START_TMO(TMO)) dut (
      .clk_50m      (clk_50m),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .ack          (ack),
      .uart_din     (uart_din),
      .uart_wr_en   (uart_wr_en),
      .uart_tx_busy (uart_tx_busy),
      .grant_id     (grant_id),
      .busy         (busy),
      .drop         (drop)
   );

   always #10 clk_50m = ~clk_50m;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: "idle or not", cycles since the grant, whether the frame started.
   bit           m_idle;
   int           m_age;
   bit           m_seen;
   int           m_ptr;
   logic [N-1:0] e_ack;
   logic         e_wr, e_busy, e_drop;
   logic [7:0]   e_din;
   logic [2:0]   e_gid;

   // Requester and transmitter behaviour
   bit         reload [N];
   bit         rnd_mode, rnd_tx, tx_dead, tx_pending;
   int         tx_delay_cfg, tx_frame_cfg, tx_delay, tx_left;
   int         txb_fall;
   logic [7:0] tx_byte;
   int         dlog[$];
   int         wr_count;
   int         exp_fair[6] = '{0, 1, 2, 3, 0, 1};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      int idx;
`ifdef UART_ARB_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= N; k++) begin
         idx = (p + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs that edge sampled.
   task automatic model_advance();
      int w;
      if (rst) begin
         m_idle = 1'b1; m_ptr = N - 1; m_age = 0; m_seen = 1'b0;
         e_ack = '0; e_wr = 1'b0; e_din = 8'h00; e_gid = 3'd0; e_drop = 1'b0;
      end else begin
         e_ack = '0; e_wr = 1'b0; e_drop = 1'b0;
         if (m_idle) begin
            if (req != '0 && !uart_tx_busy) begin
               w = pick(req, m_ptr);
               e_ack[w] = 1'b1;
               e_wr     = 1'b1;
               e_din    = req_data[8*w +: 8];
               e_gid    = 3'(w);
`ifdef UART_ARB_PRIO0_EN
               if (w != 0) m_ptr = w;
`else
               m_ptr = w;
`endif
               m_idle = 1'b0; m_age = 0; m_seen = 1'b0;
            end
         end else begin
            m_age++;
            // age 1 is the issue cycle; from age 2 on the transmitter start is watched.
            if (m_age >= 2) begin
               if (m_seen) begin
                  if (!uart_tx_busy) m_idle = 1'b1;
               end else if (uart_tx_busy) begin
                  m_seen = 1'b1;
               end else if (m_age - 1 == TMO) begin
                  e_drop = 1'b1;
                  m_idle = 1'b1;
               end
            end
         end
      end
      e_busy = !m_idle;
   endtask

   // React to DUT outputs: grant log, requester reloads, transmitter busy profile.
   task automatic observe();
      logic prev_txb;
      if (uart_wr_en === 1'b1) begin
         dlog.push_back(int'(grant_id));
         wr_count++;
         tx_byte = uart_din;
         if (rnd_tx) begin
            tx_dead      = ($urandom_range(0, 7) == 0);
            tx_delay_cfg = $urandom_range(0, 2);
            tx_frame_cfg = $urandom_range(1, 10);
         end
         if (!tx_dead) begin
            tx_pending = 1'b1;
            tx_delay   = tx_delay_cfg;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (ack[i] === 1'b1) begin
            if (rnd_mode) reload[i] = ($urandom_range(0, 1) == 1);
            if (reload[i]) begin
               req[i] = 1'b1;
               req_data[8*i +: 8] = 8'($urandom);
            end else begin
               req[i] = 1'b0;
            end
         end else if (rnd_mode && !req[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
         end
      end
      prev_txb = uart_tx_busy;
      if (tx_pending) begin
         if (tx_delay == 0) begin
            tx_pending = 1'b0;
            tx_left    = tx_frame_cfg;
         end else begin
            tx_delay--;
         end
      end
      if (tx_left > 0) begin
         uart_tx_busy = 1'b1;
         tx_left--;
      end else begin
         uart_tx_busy = 1'b0;
      end
      if (prev_txb && !uart_tx_busy) txb_fall = cyc;
   endtask

   task automatic step();
      @(negedge clk_50m);
      cyc++;
      model_advance();
      chk("ack", ack, e_ack);
      chk("uart_wr_en", uart_wr_en, e_wr);
      chk("uart_din", uart_din, e_din);
      chk("grant_id", grant_id, e_gid);
      chk("busy", busy, e_busy);
      chk("drop", drop, e_drop);
      chk("ack_onehot", $countones(ack) <= 1, 1'b1);
      observe();
   endtask

   task automatic wait_grants(input int n, input int budget, input string nm);
      int k = 0;
      while (dlog.size() < n && k < budget) begin
         step();
         k++;
      end
      chk({nm, "_timeout"}, dlog.size() >= n, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy !== 1'b0 || uart_tx_busy || req != '0) && k < budget) begin
         step();
         k++;
      end
      chk("idle_timeout", k < budget, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int k;
      int ack_cyc;
      rst = 1'b1; req = '0; req_data = '0; uart_tx_busy = 1'b0;
      rnd_mode = 1'b0; rnd_tx = 1'b0; tx_dead = 1'b0; tx_pending = 1'b0;
      tx_delay_cfg = 0; tx_frame_cfg = 6; tx_delay = 0; tx_left = 0; txb_fall = 0;
      tx_byte = 8'h00; wr_count = 0;
      m_idle = 1'b1; m_ptr = N - 1; m_age = 0; m_seen = 1'b0;
      for (int i = 0; i < N; i++) reload[i] = 1'b0;

      // Reset values
      step();
      step();
      chk("rst_ack", ack, 4'b0000);
      chk("rst_wr_en", uart_wr_en, 1'b0);
      chk("rst_din", uart_din, 8'h00);
      chk("rst_gid", grant_id, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop, 1'b0);
      rst = 1'b0;
      step();

      // Single byte from requester 2
      tx_frame_cfg = 10; tx_delay_cfg = 0; dlog.delete(); wr_count = 0;
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      wait_grants(1, 20, "single");
      chk("single_ack", ack, 4'b0100);
      chk("single_din", uart_din, 8'hA5);
      chk("single_gid", grant_id, 3'd2);
      step();
      chk("single_ack_clr", ack, 4'b0000);
      chk("single_wr_clr", uart_wr_en, 1'b0);
      k = 0;
      while (busy === 1'b1 && k < 60) begin step(); k++; end
      chk("single_busy_fall", cyc - txb_fall, 1);
      chk("single_wr_count", wr_count, 1);
      chk("single_tx_byte", tx_byte, 8'hA5);
      wait_idle(50);

      // Fairness with all four requesting and reloading after each ack
      do_reset();
      tx_frame_cfg = 6; dlog.delete();
      for (int i = 0; i < N; i++) reload[i] = 1'b1;
      req_data = 32'($urandom);
      req = 4'b1111;
      wait_grants(6, 200, "fair");
      if (dlog.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), dlog[i], exp_fair[i]);
      end
      for (int i = 0; i < N; i++) reload[i] = 1'b0;
      wait_idle(200);

      // Drop: transmitter never starts
      tx_dead = 1'b1; dlog.delete();
      req_data[7:0] = 8'h11;
      req = 4'b0001;
      wait_grants(1, 20, "drop_grant");
      ack_cyc = cyc;
      k = 0;
      while (drop !== 1'b1 && k < 20) begin step(); k++; end
      chk("drop_latency", cyc - ack_cyc, 5);
      chk("drop_back_idle", busy, 1'b0);
      step();
      chk("drop_pulse_clr", drop, 1'b0);
      tx_dead = 1'b0;
      req_data[7:0] = 8'h3C;
      req = 4'b0001;
      wait_grants(2, 20, "after_drop");
      chk("after_drop_din", uart_din, 8'h3C);
      chk("after_drop_gid", grant_id, 3'd0);
      wait_idle(60);

      // Reset in the middle of a frame
      tx_frame_cfg = 20; dlog.delete();
      req_data[23:16] = 8'h77;
      req = 4'b0100;
      wait_grants(1, 20, "mid_grant");
      repeat (4) step();
      chk("mid_in_frame", busy && uart_tx_busy, 1'b1);
      req_data[15:8] = 8'h5A;
      req = 4'b0010;
      do_reset();
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_gid", grant_id, 3'd0);
      chk("mid_rst_din", uart_din, 8'h00);
      chk("mid_rst_txb", uart_tx_busy, 1'b1);
      wait_grants(2, 40, "mid_regrant");
      chk("mid_wr_after_txfall", cyc - txb_fall, 1);
      chk("mid_gid", grant_id, 3'd1);
      chk("mid_din", uart_din, 8'h5A);
      wait_idle(60);

      // Requester 0 versus requester 3
      do_reset();
      tx_frame_cfg = 5; dlog.delete();
      reload[0] = 1'b1; reload[3] = 1'b1;
      req_data = 32'($urandom);
      req = 4'b1001;
      wait_grants(4, 100, "prio");
      if (dlog.size() >= 4) begin
`ifdef UART_ARB_PRIO0_EN
         for (int i = 0; i < 4; i++) chk($sformatf("prio_order%0d", i), dlog[i], 0);
`else
         for (int i = 0; i < 4; i++) chk($sformatf("prio_order%0d", i), dlog[i], (i % 2 == 0) ? 0 : 3);
`endif
      end
      reload[0] = 1'b0;
      wait_grants(6, 100, "prio_tail");
      if (dlog.size() >= 6) begin
         chk("prio_tail4", dlog[4], 0);
         chk("prio_tail5", dlog[5], 3);
      end
      reload[3] = 1'b0;
      wait_idle(100);

      // Randomized traffic, transmitter timing and occasional resets
      rnd_mode = 1'b1; rnd_tx = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
